// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared geometry, address-field layout and FSM encoding for the
//               direct-mapped write-through data cache.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package cache_pkg;

   localparam int ADDR_W          = 10;
   localparam int DATA_W          = 32;
   localparam int BYTES_PER_WORD  = DATA_W / 8;
   localparam int WORDS_PER_BLOCK = 4;
   localparam int NUM_LINES       = 4;

   localparam int BYTE_OFF_W = $clog2(BYTES_PER_WORD);
   localparam int WORD_OFF_W = $clog2(WORDS_PER_BLOCK);
   localparam int INDEX_W    = $clog2(NUM_LINES);
   localparam int WADDR_W    = ADDR_W - BYTE_OFF_W;
   localparam int TAG_W      = WADDR_W - WORD_OFF_W - INDEX_W;

   // Field positions within a word address (byte offset already stripped)
   localparam int WA_INDEX_LSB = WORD_OFF_W;
   localparam int WA_TAG_LSB   = WORD_OFF_W + INDEX_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/main_memory.sv
// ============================================================================
// Module      : main_memory
// Description : Byte-array backing store with a synchronous little-endian word
//               write port and a combinational word read port.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module main_memory
   import cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               we_i,
   input  logic [WADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0]  wdata_i,
   input  logic [WADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0]  rdata_o
);

   localparam int MEM_BYTES = 1 << ADDR_W;

   logic [7:0] Memory [MEM_BYTES];

   for (genvar i = 0; i < MEM_BYTES; i++) begin : g_byte
      localparam logic [WADDR_W-1:0] WORD = WADDR_W'(i / BYTES_PER_WORD);
      localparam int                 LANE = i % BYTES_PER_WORD;

      always_ff @(posedge clk) begin
         if (rst) begin
            Memory[i] <= '0;
         end else if (we_i && (waddr_i == WORD)) begin
            Memory[i] <= wdata_i[8*LANE +: 8];
         end
      end
   end

   // Lane b of the word comes from byte address {word, b}: little-endian
   for (genvar b = 0; b < BYTES_PER_WORD; b++) begin : g_rd_lane
      assign rdata_o[8*b +: 8] = Memory[{raddr_i, BYTE_OFF_W'(b)}];
   end

endmodule

`default_nettype wire

// File: rtl/cache_direct_through.sv
// ============================================================================
// Module      : cache_direct_through
// Description : Direct-mapped, write-through, write-allocate L1 data cache with
//               an internal 1 KiB main memory instance "mem".
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cache_direct_through
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              read_write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              hit_miss,
   output logic              done
);

   localparam logic [WORD_OFF_W-1:0] LAST_WORD = WORD_OFF_W'(WORDS_PER_BLOCK - 1);

   state_t state_q, state_d;

   logic                  valid_q [NUM_LINES];
   logic [TAG_W-1:0]      tag_q   [NUM_LINES];
   logic [DATA_W-1:0]     data_q  [NUM_LINES][WORDS_PER_BLOCK];

   logic [WADDR_W-1:0]    req_waddr_q;
   logic                  req_rw_q;
   logic [DATA_W-1:0]     req_wdata_q;
   logic [WORD_OFF_W-1:0] fill_cnt_q;
   logic [DATA_W-1:0]     read_data_q;
   logic                  hit_miss_q;
   logic                  done_q;

   logic                  start_miss, fill_en, fill_last, do_access, use_live;
   logic                  lookup_hit;
   logic [WADDR_W-1:0]    live_waddr, acc_waddr;
   logic [INDEX_W-1:0]    live_idx, acc_idx, req_idx;
   logic [TAG_W-1:0]      live_tag, req_tag;
   logic [WORD_OFF_W-1:0] acc_word;
   logic                  acc_rw;
   logic [DATA_W-1:0]     acc_wdata;
   logic [DATA_W-1:0]     mem_rdata;
   logic                  unused_byte_off;

   assign unused_byte_off = ^address[BYTE_OFF_W-1:0];

   assign live_waddr = address[ADDR_W-1:BYTE_OFF_W];
   assign live_idx   = live_waddr[WA_INDEX_LSB +: INDEX_W];
   assign live_tag   = live_waddr[WA_TAG_LSB +: TAG_W];
   assign req_idx    = req_waddr_q[WA_INDEX_LSB +: INDEX_W];
   assign req_tag    = req_waddr_q[WA_TAG_LSB +: TAG_W];
   assign lookup_hit = valid_q[live_idx] && (tag_q[live_idx] == live_tag);

   // A hit is served straight from the port; RESP replays the latched request
   assign acc_waddr = use_live ? live_waddr : req_waddr_q;
   assign acc_rw    = use_live ? read_write : req_rw_q;
   assign acc_wdata = use_live ? write_data : req_wdata_q;
   assign acc_idx   = acc_waddr[WA_INDEX_LSB +: INDEX_W];
   assign acc_word  = acc_waddr[WORD_OFF_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      start_miss = 1'b0;
      fill_en    = 1'b0;
      fill_last  = 1'b0;
      do_access  = 1'b0;
      use_live   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (lookup_hit) begin
                  do_access = 1'b1;
                  use_live  = 1'b1;
               end else begin
                  start_miss = 1'b1;
                  state_d    = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            fill_en = 1'b1;
            if (fill_cnt_q == LAST_WORD) begin
               fill_last = 1'b1;
               state_d   = ST_RESP;
            end
         end
         ST_RESP: begin
            do_access = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_waddr_q <= '0;
         req_rw_q    <= 1'b0;
         req_wdata_q <= '0;
         fill_cnt_q  <= '0;
         read_data_q <= '0;
         hit_miss_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= do_access;
         if (start_miss) begin
            hit_miss_q  <= 1'b0;
            req_waddr_q <= live_waddr;
            req_rw_q    <= read_write;
            req_wdata_q <= write_data;
            fill_cnt_q  <= '0;
         end
         if (fill_en) begin
            fill_cnt_q <= fill_cnt_q + WORD_OFF_W'(1);
         end
         if (do_access) begin
            hit_miss_q <= use_live;
            if (!acc_rw) begin
               read_data_q <= data_q[acc_idx][acc_word];
            end
         end
      end
   end

   for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
      localparam logic [INDEX_W-1:0] LINE = INDEX_W'(l);

      // Invalidate on miss so an aborted fill never leaves a half-written line valid
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q[l] <= 1'b0;
            tag_q[l]   <= '0;
         end else if (start_miss && (live_idx == LINE)) begin
            valid_q[l] <= 1'b0;
         end else if (fill_last && (req_idx == LINE)) begin
            valid_q[l] <= 1'b1;
            tag_q[l]   <= req_tag;
         end
      end

      for (genvar w = 0; w < WORDS_PER_BLOCK; w++) begin : g_word
         localparam logic [WORD_OFF_W-1:0] WORD = WORD_OFF_W'(w);

         always_ff @(posedge clk) begin
            if (rst) begin
               data_q[l][w] <= '0;
            end else if (fill_en && (req_idx == LINE) && (fill_cnt_q == WORD)) begin
               data_q[l][w] <= mem_rdata;
            end else if (do_access && acc_rw && (acc_idx == LINE) && (acc_word == WORD)) begin
               data_q[l][w] <= acc_wdata;
            end
         end
      end
   end

   main_memory mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (do_access & acc_rw),
      .waddr_i (acc_waddr),
      .wdata_i (acc_wdata),
      .raddr_i ({req_tag, req_idx, fill_cnt_q}),
      .rdata_o (mem_rdata)
   );

   assign read_data = read_data_q;
   assign hit_miss  = hit_miss_q;
   assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_direct_through.sv
// ============================================================================
// Module      : tb_cache_direct_through
// Description : Directed self-checking bench for cache_direct_through.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cache_direct_through;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        read_write;
   logic [9:0]  address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        hit_miss;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cache_direct_through dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .read_write (read_write),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .hit_miss   (hit_miss),
      .done       (done)
   );

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input int a);
      return {dut.mem.Memory[a+3], dut.mem.Memory[a+2], dut.mem.Memory[a+1], dut.mem.Memory[a]};
   endfunction

   // Called #1 after a clock edge; returns #1 after the edge following done
   task automatic access(input string tag, input logic rw, input logic [9:0] a,
                         input logic [31:0] wd, input logic exp_hit,
                         input logic [31:0] exp_rd, input logic chk_rd);
      int lat;
      req_valid  = 1'b1;
      read_write = rw;
      address    = a;
      write_data = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check_value({tag, ".latency"}, 32'(lat), exp_hit ? 32'd1 : 32'd6);
      check_value({tag, ".hit"}, 32'(hit_miss), 32'(exp_hit));
      if (chk_rd) check_value({tag, ".rdata"}, read_data, exp_rd);
      @(posedge clk); #1;
      check_value({tag, ".pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int lat;
      int pulses;
      rst        = 1'b1;
      req_valid  = 1'b0;
      read_write = 1'b0;
      address    = '0;
      write_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      check_value("reset.rdata", read_data, 32'h0);
      check_value("reset.hit", 32'(hit_miss), 32'd0);
      check_value("reset.done", 32'(done), 32'd0);
      check_value("reset.mem0", mem_word(0), 32'h0);

      access("rd000_cold", 1'b0, 10'h000, 32'h0, 1'b0, 32'h0000_0000, 1'b1);
      access("wr000_hit", 1'b1, 10'h000, 32'h0000_00FF, 1'b1, 32'h0, 1'b0);
      check_value("wt.mem000", mem_word(0), 32'h0000_00FF);
      access("rd000_hit", 1'b0, 10'h000, 32'h0, 1'b1, 32'h0000_00FF, 1'b1);

      access("rd200_conf", 1'b0, 10'h200, 32'h0, 1'b0, 32'h0, 1'b1);
      access("rd000_evict", 1'b0, 10'h000, 32'h0, 1'b0, 32'h0000_00FF, 1'b1);
      access("rd300_conf", 1'b0, 10'h300, 32'h0, 1'b0, 32'h0, 1'b1);
      access("rd200_again", 1'b0, 10'h200, 32'h0, 1'b0, 32'h0, 1'b1);
      check_value("conf.mem000", mem_word(0), 32'h0000_00FF);

      access("wr044_alloc", 1'b1, 10'h044, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0);
      check_value("alloc.mem044", mem_word('h44), 32'hA5A5_A5A5);
      check_value("alloc.mem040", mem_word('h40), 32'h0);
      access("rd040_hit", 1'b0, 10'h040, 32'h0, 1'b1, 32'h0, 1'b1);
      access("rd044_hit", 1'b0, 10'h044, 32'h0, 1'b1, 32'hA5A5_A5A5, 1'b1);

      access("wr01c_alloc", 1'b1, 10'h01C, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
      check_value("alloc.mem01c", mem_word('h1C), 32'h1234_5678);
      access("rd014_hit", 1'b0, 10'h014, 32'h0, 1'b1, 32'h0, 1'b1);
      access("rd01c_hit", 1'b0, 10'h01C, 32'h0, 1'b1, 32'h1234_5678, 1'b1);

      // req_valid held through the miss with a conflicting write on the bus
      req_valid  = 1'b1;
      read_write = 1'b0;
      address    = 10'h000;
      @(posedge clk); #1;
      read_write = 1'b1;
      address    = 10'h340;
      write_data = 32'hDEAD_BEEF;
      lat = 1;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      req_valid = 1'b0;
      check_value("hold.latency", 32'(lat), 32'd6);
      check_value("hold.hit", 32'(hit_miss), 32'd0);
      check_value("hold.rdata", read_data, 32'h0000_00FF);
      pulses = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check_value("hold.extra_pulses", 32'(pulses), 32'd0);
      check_value("hold.mem340", mem_word('h340), 32'h0);

      // Reset arrives two cycles into a fill
      req_valid  = 1'b1;
      read_write = 1'b0;
      address    = 10'h0C0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_value("rstfill.rdata", read_data, 32'h0);
      check_value("rstfill.done", 32'(done), 32'd0);
      check_value("rstfill.mem000", mem_word(0), 32'h0);
      pulses = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check_value("rstfill.pulses", 32'(pulses), 32'd0);
      access("rd0c0_after_rst", 1'b0, 10'h0C0, 32'h0, 1'b0, 32'h0, 1'b1);
      access("rd01c_after_rst", 1'b0, 10'h01C, 32'h0, 1'b0, 32'h0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
